// File: rtl/ob_seq_pkg.sv
// Shared types and helpers for the object-processor memory sequencer:
// state encoding, default widths and the one-hot requester picker.
package ob_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int AW     = 21;
  localparam int CW     = 4;
  localparam int MAXREQ = 8;

  // Returns a one-hot pick of the first set bit of req, searching upward from
  // start and wrapping at n. Fixed priority simply passes start = 0.
  function automatic logic [MAXREQ-1:0] onehot_pick(
    input logic [MAXREQ-1:0] req,
    input logic [2:0]        start,
    input logic [3:0]        n
  );
    logic [MAXREQ-1:0] pick;
    logic              found;
    logic [3:0]        idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = 4'(start) + 4'(i);
      if (idx >= n) idx = idx - n;
      if ((4'(i) < n) && !found && req[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ob_ack_shift.sv
// LAT-stage token pipe: one token per accepted phrase, emerging LAT cycles
// later as the latch strobe; flags the final token and an empty pipe.
module ob_ack_shift #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  output logic o_tok,
  output logic o_last,
  output logic o_empty
);

  logic [LAT-1:0] r_pipe;
  logic           w_rest;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the pipe shifts by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_push;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rest = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      w_rest = w_rest | r_pipe[i];
    end
  end

  assign o_tok   = r_pipe[LAT-1];
  assign o_last  = r_pipe[LAT-1] & ~w_rest;
  assign o_empty = ~|r_pipe;

endmodule

// File: rtl/ob_mem_sequencer.sv
// Memory-bus sequencer: grants one requester, issues its phrase burst and
// returns delayed latch/done strobes. Define OB_SEQ_RR_EN for round-robin.
module ob_mem_sequencer #(
  parameter int NREQ = 3,
  parameter int AW   = ob_seq_pkg::AW,
  parameter int CW   = ob_seq_pkg::CW,
  parameter int LAT  = 1
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*CW-1:0] req_cnt,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    latch,
  output logic [NREQ-1:0]    done,
  output logic               busreq,
  output logic [AW-1:0]      busaddr,
  input  logic               busack
);

  import ob_seq_pkg::*;

  seq_state_t        r_state;
  logic [NREQ-1:0]   r_gnt;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_cnt;
  logic              r_busreq;

  logic [MAXREQ-1:0] w_pick8;
  logic [NREQ-1:0]   w_win;
  logic [AW-1:0]     w_win_addr;
  logic [CW-1:0]     w_win_cnt;
  logic              w_ack;
  logic              w_tok;
  logic              w_last;
  logic              w_empty;
  logic              w_unused_pick;

`ifdef OB_SEQ_RR_EN
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win_idx;
  logic [PW-1:0] w_ptr_next;

  assign w_pick8 = onehot_pick(MAXREQ'(req), 3'(r_ptr), 4'(NREQ));

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  assign w_ptr_next = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if ((r_state == IDLE) && (|req)) begin
      r_ptr <= w_ptr_next;
    end
  end
`else
  assign w_pick8 = onehot_pick(MAXREQ'(req), 3'd0, 4'(NREQ));
`endif

  assign w_win         = w_pick8[NREQ-1:0];
  assign w_unused_pick = ^w_pick8;

  always_comb begin
    w_win_addr = '0;
    w_win_cnt  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_addr = req_addr[i*AW +: AW];
        w_win_cnt  = req_cnt[i*CW +: CW];
      end
    end
  end

  // Acks only count while the request is actually on the bus.
  assign w_ack = (r_state == REQ) & busack;

  ob_ack_shift #(
    .LAT (LAT)
  ) u_ack_shift (
    .clk     (sys_clk),
    .rst     (reset),
    .i_push  (w_ack),
    .o_tok   (w_tok),
    .o_last  (w_last),
    .o_empty (w_empty)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_busreq <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt    <= w_win;
            r_addr   <= w_win_addr;
            r_cnt    <= w_win_cnt;
            r_busreq <= 1'b1;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (busack) begin
            r_addr <= r_addr + AW'(1);
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CW'(1);
            end else begin
              r_busreq <= 1'b0;
              r_state  <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // An empty pipe here cannot occur in normal flow; it just recovers.
          if (w_last || w_empty) begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busreq  = r_busreq;
  assign busaddr = r_addr;
  assign latch   = w_tok ? r_gnt : '0;
  assign done    = (w_last && (r_state == DRAIN)) ? r_gnt : '0;

endmodule

// File: doc/ob_mem_sequencer.md
Name: ob_mem_sequencer

Overview:
- Shares the object-processor memory bus port between NREQ internal requesters (object fetch, bitmap data fetch, scaled-fetch).
- Grants one requester at a time and issues its burst of consecutive phrase reads.
- Counts bus acknowledges and generates that requester's delayed per-phrase data-latch strobes and a completion strobe.
- Sits between the requester datapaths and the bus-interface handshake.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 21, phrase address width
CW, 4, burst count width; count value n means n+1 phrases
LAT, 1, cycles from sampled busack to latch strobe (1..4)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  request per requester, level, held until its done
req_addr  in  NREQ*AW  start phrase address per requester, slice i = requester i
req_cnt  in  NREQ*CW  burst length minus one per requester
gnt  out  NREQ  one-hot grant, held for the whole transaction
latch  out  NREQ  one-cycle strobe per returned phrase, to granted requester only
done  out  NREQ  one-cycle strobe with the final phrase's latch
busreq  out  1  bus request
busaddr  out  AW  current phrase address
busack  in  1  bus accepted current phrase this cycle

Behaviour:
- Reset, asynchronous: gnt, latch, done, busreq and busaddr are all 0; state IDLE; ack pipe cleared; round-robin pointer 0.
- Reset mid-transaction aborts it: no further latch or done strobes.
- States: IDLE, REQ, DRAIN.
- IDLE: if any req bit is set, pick a winner w.
  - At the next edge: gnt[w]=1, busaddr=req_addr[w], capture remaining count = req_cnt[w], busreq=1, go to REQ.
  - Latency: req high in cycle 0 gives gnt and busreq in cycle 1.
- REQ: busreq=1; busaddr is stable until busack.
  - On each sampled busack: push a token into the LAT-deep ack pipe, busaddr+1 (modulo 2^AW, wraps silently).
  - If remaining count ≠ 0: decrement it and stay in REQ. Back-to-back acks are legal, one phrase per cycle.
  - If remaining count = 0: clear busreq at the same edge and go to DRAIN.
- Ack pipe: latch[w] is asserted exactly LAT cycles after each cycle in which busack was sampled high. Token order is preserved.
- DRAIN: wait for the pipe to empty.
  - The cycle in which the last token emerges asserts both latch[w] and done[w].
  - At the following edge: gnt=0, go to IDLE.
- Arbitration is evaluated only in IDLE. Default is fixed priority: lowest index wins.
- A req still high in the first IDLE cycle after done is a new request.
- Dropping req[w] mid-transaction has no effect; the burst completes.
- Changes to req_addr or req_cnt after the grant edge are ignored.
- busack while busreq=0 is ignored: no token, no address change.
- A burst of 2^CW phrases (cnt all ones) is legal.

Optional Feature:
- OB_SEQ_RR_EN defined: round-robin arbitration. The search starts at the index after the last winner (wrapping NREQ-1 to 0); the pointer updates at the grant edge. Reset sets the pointer to 0, so requester 0 has first priority.
- Undefined: fixed lowest-index priority; no pointer register.

Decomposition:
- Package ob_seq_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, DRAIN=2'd2);
  - default width constants AW, CW;
  - the one-hot select function used by both arbitration modes.
- Sub-module ob_ack_shift: the LAT-stage token shift register with an empty flag (async reset). It is instantiated once; it is the sequenced form of the single ack/latch stage.

Test Plan:
- Single burst: req[1]=1, addr=0x00100, cnt=2, busack held high → busaddr 0x00100/0x00101/0x00102 on cycles 1-3, busreq low from cycle 4, latch[1] on cycles 2-4, done[1] on cycle 4, gnt=0 on cycle 5.
- Stalled acks: cnt=1, busack pulses in cycles 3 and 7 → latch[0] at cycles 3+LAT and 7+LAT only; busaddr holds 0 until cycle 3.
- Wrap: addr=0x1FFFFF, cnt=1 → second phrase address 0x000000.
- Contention: req=3'b111 together, fixed mode → grant order 0,1,2. With OB_SEQ_RR_EN and requester 0 re-requesting immediately → order 0,1,2,0.
- Async reset asserted in REQ after one ack with LAT=2 → all outputs 0 immediately; no latch appears afterwards; after release, req restarts cleanly from IDLE.
- Spurious busack in IDLE, and req[w] dropped mid-burst → no latch from the spurious ack; the burst still completes with done[w].
